// File: rtl/inst_mem_loader.sv
// Byte-array instruction memory with a registered fetch port, a streaming
// program-load engine (IDLE/LOAD/DONE) and a combinational debug read port.
module inst_mem_loader #(
  parameter  int XLEN        = 32,
  parameter  int DEPTH_BYTES = 1024,
  localparam int AW          = $clog2(DEPTH_BYTES),
  localparam int BYTES       = XLEN / 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_req,
  input  logic [XLEN-1:0]  fetch_addr,
  output logic             fetch_ready,
  output logic             fetch_valid,
  output logic [XLEN-1:0]  fetch_data,
  output logic             fetch_fault,
  input  logic             load_start,
  input  logic [XLEN-1:0]  load_base,
  input  logic             load_valid,
  input  logic [XLEN-1:0]  load_data,
  input  logic [BYTES-1:0] load_be,
  input  logic             load_last,
  output logic             load_ready,
  output logic             load_busy,
  output logic             load_done,
  output logic [AW:0]      load_count,
  input  logic             debug_en,
  input  logic [XLEN-1:0]  debug_addr,
  output logic [XLEN-1:0]  debug_data
);

  localparam int OFF = $clog2(BYTES);
  localparam logic [AW:0] CNT_MAX = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0] CNT_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t        state;
  logic [AW-1:0] wptr;
  logic [7:0]    mem [DEPTH_BYTES];

  logic [AW-1:0] fetch_base, debug_base;
  logic [XLEN-1:0] fetch_word, debug_word;
  logic          fetch_accept, fetch_bad, load_we;

  assign fetch_ready  = (state == IDLE);
  assign load_ready   = (state == LOAD);
  assign load_busy    = (state != IDLE);
  assign fetch_accept = fetch_req && fetch_ready;
  // A beat presented in the reset cycle must not land in memory.
  assign load_we      = (state == LOAD) && load_valid && !reset;

  assign fetch_base = {fetch_addr[AW-1:OFF], {OFF{1'b0}}};
  assign debug_base = {debug_addr[AW-1:OFF], {OFF{1'b0}}};
  assign fetch_bad  = (|fetch_addr[OFF-1:0]) || (|fetch_addr[XLEN-1:AW]);

  // Address bits the debug port and the load base deliberately ignore.
  logic unused_bits;
  assign unused_bits = ^{load_base[XLEN-1:AW], load_base[OFF-1:0],
                         debug_addr[XLEN-1:AW], debug_addr[OFF-1:0]};

  // NOTE: every variable written in always_comb is fully assigned on each
  // pass (here by the loop over all byte lanes) so no latch is inferred.
  always_comb begin
    for (int k = 0; k < BYTES; k++) begin
      fetch_word[8*k +: 8] = mem[fetch_base + AW'(k)];
      debug_word[8*k +: 8] = mem[debug_base + AW'(k)];
    end
  end

  assign debug_data = debug_en ? debug_word : '0;

  // NOTE: the storage array has no reset; program contents survive a reset
  // and clearing it would force a flop-based implementation.
  always_ff @(posedge clk) begin
    for (int k = 0; k < BYTES; k++) begin
      if (load_we && load_be[k]) mem[wptr + AW'(k)] <= load_data[8*k +: 8];
    end
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      wptr        <= '0;
      load_count  <= '0;
      fetch_valid <= 1'b0;
      fetch_data  <= '0;
      fetch_fault <= 1'b0;
      load_done   <= 1'b0;
    end else begin
      fetch_valid <= fetch_accept;
      load_done   <= 1'b0;
      if (fetch_accept) begin
        fetch_fault <= fetch_bad;
        fetch_data  <= fetch_bad ? '0 : fetch_word;
      end
      case (state)
        IDLE: begin
          if (load_start) begin
            state      <= LOAD;
            wptr       <= {load_base[AW-1:OFF], {OFF{1'b0}}};
            load_count <= '0;
          end
        end
        LOAD: begin
          if (load_valid) begin
            wptr <= wptr + AW'(BYTES);
            if (load_count != CNT_MAX) load_count <= load_count + CNT_ONE;
            if (load_last) begin
              state     <= DONE;
              load_done <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: load sessions, a fetch vector table,
// and hand sequences for handshake, reset-abort and saturation corners.
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ready, fetch_valid, fetch_fault;
  logic [31:0] fetch_data;
  logic        load_start;
  logic [31:0] load_base;
  logic        load_valid;
  logic [31:0] load_data;
  logic [3:0]  load_be;
  logic        load_last;
  logic        load_ready, load_busy, load_done;
  logic [10:0] load_count;
  logic        debug_en;
  logic [31:0] debug_addr, debug_data;

  int total = 0;
  int bad   = 0;

  logic [31:0] lw [16];
  logic [3:0]  lb [16];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] exp_data;
    logic        exp_fault;
  } fetch_vec_t;

  fetch_vec_t vec [10];

  inst_mem_loader dut (
    .clk(clk), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_ready(fetch_ready),
    .fetch_valid(fetch_valid), .fetch_data(fetch_data), .fetch_fault(fetch_fault),
    .load_start(load_start), .load_base(load_base), .load_valid(load_valid),
    .load_data(load_data), .load_be(load_be), .load_last(load_last),
    .load_ready(load_ready), .load_busy(load_busy), .load_done(load_done),
    .load_count(load_count), .debug_en(debug_en), .debug_addr(debug_addr),
    .debug_data(debug_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic dbg(input logic [31:0] addr, input logic [31:0] exp);
    debug_en = 1'b1;
    debug_addr = addr;
    #1;
    check($sformatf("debug@%h", addr), debug_data, exp);
    debug_en = 1'b0;
  endtask

  // Called and returns at a negedge.
  task automatic load_session(input logic [31:0] base, input int n, input logic [31:0] exp_cnt);
    load_start = 1'b1;
    load_base  = base;
    @(negedge clk);
    load_start = 1'b0;
    check("load_busy", load_busy, 1);
    check("load_ready", load_ready, 1);
    for (int i = 0; i < n; i++) begin
      load_valid = 1'b1;
      load_data  = lw[i];
      load_be    = lb[i];
      load_last  = (i == n - 1);
      @(negedge clk);
    end
    load_valid = 1'b0;
    load_last  = 1'b0;
    check("load_done", load_done, 1);
    check("load_count", load_count, exp_cnt);
    @(negedge clk);
    check("load_done_drop", load_done, 0);
    check("load_busy_idle", load_busy, 0);
  endtask

  task automatic fetch(input logic [31:0] addr, input logic [31:0] exp_d, input logic exp_f);
    fetch_req  = 1'b1;
    fetch_addr = addr;
    check("fetch_ready", fetch_ready, 1);
    @(negedge clk);
    fetch_req = 1'b0;
    check($sformatf("fetch_valid@%h", addr), fetch_valid, 1);
    check($sformatf("fetch_data@%h", addr), fetch_data, exp_d);
    check($sformatf("fetch_fault@%h", addr), fetch_fault, exp_f);
    @(negedge clk);
    check("fetch_valid_drop", fetch_valid, 0);
    check("fetch_data_hold", fetch_data, exp_d);
  endtask

  initial begin
    vec[0] = '{32'h010, 32'hDEADBEEF, 1'b0};
    vec[1] = '{32'h014, 32'h00000013, 1'b0};
    vec[2] = '{32'h020, 32'h11BB33DD, 1'b0};
    vec[3] = '{32'h024, 32'h77777777, 1'b0};
    vec[4] = '{32'h3FC, 32'hCAFE0001, 1'b0};
    vec[5] = '{32'h000, 32'hCAFE0002, 1'b0};
    vec[6] = '{32'h012, 32'h00000000, 1'b1};
    vec[7] = '{32'h400, 32'h00000000, 1'b1};
    vec[8] = '{32'h401, 32'h00000000, 1'b1};
    vec[9] = '{32'hFFFFFFFC, 32'h00000000, 1'b1};

    reset = 1'b1; fetch_req = 1'b0; fetch_addr = '0;
    load_start = 1'b0; load_base = '0; load_valid = 1'b0; load_data = '0;
    load_be = '0; load_last = 1'b0; debug_en = 1'b0; debug_addr = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_fetch_valid", fetch_valid, 0);
    check("rst_fetch_data", fetch_data, 0);
    check("rst_load_count", load_count, 0);
    check("rst_load_done", load_done, 0);
    check("rst_busy", load_busy, 0);
    check("rst_fetch_ready", fetch_ready, 1);

    lw[0] = 32'hDEADBEEF; lw[1] = 32'h00000013; lb[0] = 4'hF; lb[1] = 4'hF;
    load_session(32'h10, 2, 2);

    lw[0] = 32'h77777777; load_session(32'h24, 1, 1);
    lw[0] = 32'h11223344; load_session(32'h20, 1, 1);

    // Write pointer now sits at 0x24; a beat in IDLE must not write there.
    load_valid = 1'b1; load_data = 32'h99999999; load_be = 4'hF;
    @(negedge clk);
    load_valid = 1'b0;
    dbg(32'h24, 32'h77777777);
    dbg(32'h20, 32'h11223344);

    // be bit k writes byte k: bytes 0 and 2 take the new value.
    lw[0] = 32'hAABBCCDD; lb[0] = 4'b0101;
    load_session(32'h20, 1, 1);
    dbg(32'h20, 32'h11BB33DD);

    lw[0] = 32'hCAFE0001; lw[1] = 32'hCAFE0002; lb[0] = 4'hF; lb[1] = 4'hF;
    load_session(32'h3FC, 2, 2);
    dbg(32'h000, 32'hCAFE0002);
    dbg(32'h3FC, 32'hCAFE0001);
    dbg(32'h410, 32'hDEADBEEF);

    for (int i = 0; i < 10; i++) fetch(vec[i].addr, vec[i].exp_data, vec[i].exp_fault);

    // Back-to-back accepts.
    fetch_req = 1'b1; fetch_addr = 32'h10;
    @(negedge clk);
    fetch_addr = 32'h14;
    check("b2b_valid0", fetch_valid, 1);
    check("b2b_data0", fetch_data, 32'hDEADBEEF);
    @(negedge clk);
    fetch_req = 1'b0;
    check("b2b_valid1", fetch_valid, 1);
    check("b2b_data1", fetch_data, 32'h00000013);
    @(negedge clk);
    check("b2b_valid_drop", fetch_valid, 0);

    // load_start with fetch_req in IDLE, fetch held through LOAD/DONE.
    load_start = 1'b1; load_base = 32'h40; fetch_req = 1'b1; fetch_addr = 32'h14;
    @(negedge clk);
    check("sim_fetch_valid", fetch_valid, 1);
    check("sim_fetch_data", fetch_data, 32'h00000013);
    check("sim_busy", load_busy, 1);
    check("sim_fetch_ready", fetch_ready, 0);
    load_base = 32'h200; fetch_addr = 32'h10;
    load_valid = 1'b1; load_data = 32'h55555555; load_be = 4'hF; load_last = 1'b1;
    @(negedge clk);
    load_start = 1'b0; load_valid = 1'b0; load_last = 1'b0;
    check("held_fetch_valid_load", fetch_valid, 0);
    check("held_load_done", load_done, 1);
    check("held_fetch_ready_done", fetch_ready, 0);
    check("held_count", load_count, 1);
    @(negedge clk);
    check("held_fetch_valid_done", fetch_valid, 0);
    check("held_fetch_ready_idle", fetch_ready, 1);
    @(negedge clk);
    fetch_req = 1'b0;
    check("held_fetch_valid_idle", fetch_valid, 1);
    check("held_fetch_data", fetch_data, 32'hDEADBEEF);
    dbg(32'h40, 32'h55555555);

    // Reset after one of three beats.
    lw[0] = 32'hA0; lw[1] = 32'hA1; lw[2] = 32'hA2;
    lb[0] = 4'hF; lb[1] = 4'hF; lb[2] = 4'hF;
    load_session(32'h80, 3, 3);
    load_start = 1'b1; load_base = 32'h80;
    @(negedge clk);
    load_start = 1'b0; load_valid = 1'b1; load_data = 32'hB0; load_be = 4'hF;
    @(negedge clk);
    load_data = 32'hB1; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; load_valid = 1'b0;
    check("abort_busy", load_busy, 0);
    check("abort_done", load_done, 0);
    check("abort_count", load_count, 0);
    @(negedge clk);
    check("abort_done_later", load_done, 0);
    dbg(32'h80, 32'hB0);
    dbg(32'h84, 32'hA1);
    dbg(32'h88, 32'hA2);

    // Zero byte-enable beat still counts and advances.
    lw[0] = 32'hFFFFFFFF; lb[0] = 4'h0; lw[1] = 32'hC8; lb[1] = 4'hF;
    load_session(32'h84, 2, 2);
    dbg(32'h84, 32'hA1);
    dbg(32'h88, 32'hC8);

    debug_addr = 32'h10; #1;
    check("debug_disabled", debug_data, 0);

    // Beat count saturates at 2^AW = 1024.
    load_start = 1'b1; load_base = 32'h0;
    @(negedge clk);
    load_start = 1'b0;
    for (int i = 0; i < 1030; i++) begin
      load_valid = 1'b1; load_be = 4'h0; load_data = 32'h0; load_last = (i == 1029);
      @(negedge clk);
    end
    load_valid = 1'b0; load_last = 1'b0;
    check("sat_done", load_done, 1);
    check("sat_count", load_count, 32'h400);
    @(negedge clk);
    check("sat_count_hold", load_count, 32'h400);
    dbg(32'h10, 32'hDEADBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
